// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants: XLEN, NOP encoding,
// control-flow opcodes and the fetch queue entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            ctrl_flow;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Flags JAL/JALR/BRANCH opcodes; purely combinational, zero latency.
// No handshake: the result is consumed in the same cycle as the opcode.
module fetch_predecode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       ctrl_flow
);

  assign ctrl_flow = (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                     (opcode == OPC_BRANCH);

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue; 1 cycle push-to-head latency.
// in_ready_o drops only when full (never looks at out_ready_i); flush empties in one cycle.
// Optional predecode flag storage enabled by FETCH_QUEUE_PREDECODE_EN.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       in_valid_i,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [31:0]                in_instr_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [31:0]                out_instr_o,
  output logic                       out_ctrl_flow_o,
  input  logic                       out_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and >= 2");
  end

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic            push, pop;
  fetch_entry_t    head;

  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush leaves entry contents alone; only pointers and occupancy clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= NOP_INSTR;
      end
    end else if (push) begin
      pc_q[wr_ptr]    <= in_pc_i;
      instr_q[wr_ptr] <= in_instr_i;
    end
  end

`ifdef FETCH_QUEUE_PREDECODE_EN
  logic             in_ctrl_flow;
  logic [DEPTH-1:0] cf_q;

  fetch_predecode u_predecode (
    .opcode    (in_instr_i[6:0]),
    .ctrl_flow (in_ctrl_flow)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   cf_q         <= '0;
    else if (push) cf_q[wr_ptr] <= in_ctrl_flow;
  end

  assign head = '{pc: pc_q[rd_ptr], instr: instr_q[rd_ptr], ctrl_flow: cf_q[rd_ptr]};
`else
  assign head = '{pc: pc_q[rd_ptr], instr: instr_q[rd_ptr], ctrl_flow: 1'b0};
`endif

  assign out_pc_o        = head.pc;
  assign out_instr_o     = head.instr;
  assign out_ctrl_flow_o = head.ctrl_flow;
  assign count_o         = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Captures each fetched `{pc, instr}` pair under a valid/ready handshake, buffers up to `DEPTH` entries so decode stalls do not lose fetched instructions, and presents the oldest entry to decode from registered storage. A redirect flush from execute empties the queue in one cycle.

## Interface
- `DEPTH`, 2: number of entries; must be a power of two and ≥ 2 (elaboration-time `$error` otherwise).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `in_valid_i`  in  1  fetch presents a valid instruction this cycle.
- `in_pc_i`  in  XLEN  PC of the presented instruction.
- `in_instr_i`  in  32  presented instruction word.
- `in_ready_o`  out  1  queue can accept; fetch must hold its PC while low.
- `out_valid_o`  out  1  head entry valid.
- `out_pc_o`  out  XLEN  head entry PC.
- `out_instr_o`  out  32  head entry instruction.
- `out_ctrl_flow_o`  out  1  head entry is a JAL, JALR or BRANCH (see Configuration).
- `out_ready_i`  in  1  decode consumes the head this cycle.
- `flush_i`  in  1  redirect; discard all entries.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: `DEPTH`-entry circular buffer of `fetch_entry_t`, read pointer `rd_ptr`, write pointer `wr_ptr` (each $clog2(DEPTH) bits, natural wrap), occupancy counter `count`.
- Push: `in_valid_i && in_ready_o && !flush_i` writes the entry at `wr_ptr`; `wr_ptr` increments.
- Pop: `out_valid_o && out_ready_i && !flush_i` increments `rd_ptr`.
- `count` update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `in_ready_o = (count != DEPTH)`. It depends only on registered state, never on `out_ready_i`. A full queue refuses a push even while popping.
- `out_valid_o = (count != 0)`. The `out_*` fields are read combinationally from the entry at `rd_ptr`. There is no input-to-output bypass.
- Flush has highest priority:
  - `count`, `rd_ptr` and `wr_ptr` go to 0.
  - The concurrent input is dropped and no pop occurs.
  - Entry contents are not cleared.
- Empty with `out_ready_i` high: no pop, no pointer change.
- `count_o = count`.

## Timing
- Reset values:
  - `count`, `rd_ptr` and `wr_ptr` are 0.
  - All entries hold `pc = 0`, `instr = NOP_INSTR` (32'h0000_0013) and `ctrl_flow = 0`.
  - Outputs: `out_valid_o = 0`, `in_ready_o = 1`, `count_o = 0`, `out_pc_o = 0`, `out_instr_o = 32'h0000_0013`, `out_ctrl_flow_o = 0`.
- Latency: an entry pushed at edge N is visible on `out_*`, with `out_valid_o = 1`, in the cycle after edge N. Minimum fetch-to-decode latency is one cycle.
- Throughput: one push and one pop per cycle at any non-full, non-empty occupancy.
- After a flush at edge N: `out_valid_o = 0` and `in_ready_o = 1` in the cycle after N.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Entries present before reset are lost.

## Configuration
- `FETCH_QUEUE_PREDECODE_EN` defined:
  - On push, `ctrl_flow` is computed from `in_instr_i[6:0]`. It is 1 for opcodes 7'b1101111 (JAL), 7'b1100111 (JALR) and 7'b1100011 (BRANCH), and 0 otherwise.
  - The flag is stored with the entry and driven on `out_ctrl_flow_o`.
- Not defined:
  - No predecode logic and no storage bit are built.
  - `out_ctrl_flow_o` is tied to 0.
  - The port list is identical either way.

## Structure
- `riscv_pkg` holds `XLEN`, `NOP_INSTR`, the opcode constants `OPC_JAL`, `OPC_JALR` and `OPC_BRANCH`, and the `fetch_entry_t` struct `{pc, instr, ctrl_flow}`.
- One sub-module, `fetch_predecode` (combinational opcode-to-flag), is instantiated only under `FETCH_QUEUE_PREDECODE_EN`.
- Storage, pointers and counter live in `fetch_queue`.

## Test plan
- Reset then idle: `out_valid_o = 0`, `in_ready_o = 1`, `count_o = 0`, `out_instr_o = 32'h0000_0013`.
- Push pc 0x8000_0000 / 0x0000_0093 and pc 0x8000_0004 / 0x0000_0113 with `out_ready_i = 0`:
  - `count_o = 2`, `in_ready_o = 0`.
  - A third push (pc 0x8000_0008) is refused and `count_o` stays 2.
  - Draining then returns pc 0x8000_0000 followed by pc 0x8000_0004.
- Continuous push and pop with `out_ready_i = 1`: 8 sequential PCs from 0x8000_0000 step 4 emerge in order, one per cycle after one cycle of latency. `count_o` holds at 1 and the pointers wrap cleanly.
- Full queue with `flush_i = 1`, `in_valid_i = 1` and `out_ready_i = 1` in the same cycle: the next cycle shows `count_o = 0`, `out_valid_o = 0` and `in_ready_o = 1`; no entry is popped and the input is dropped.
- Predecode: push 0x0000_006F, 0x0000_8067, 0x0000_0463 and 0x0000_0013.
  - With `FETCH_QUEUE_PREDECODE_EN`, `out_ctrl_flow_o` reads 1, 1, 1, 0.
  - Without it, all four read 0.
- Assert `rstn_i` low mid-cycle with 2 entries queued: `out_valid_o` and `count_o` drop to 0 before the next clock edge.
